writeback_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file; owns its single write port (write_enable / addr_rd / data_rd).
- Merges the fixed-latency ALU result stream with a variable-latency load-return stream.
- Buffers load returns in a small FIFO and tracks registers with outstanding loads in a busy scoreboard. Decode uses the scoreboard to stall RAW/WAW hazards on load destinations.

---
 rtl/writeback_arbiter.sv | 129 ++++++++++++
 tb/tb_writeback_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback stage arbiter: merges the ALU result stream with buffered load returns onto
// the single register-file write port and keeps a busy scoreboard for outstanding loads.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        load_issue_valid,
    input  logic [4:0]  load_issue_rd,
    input  logic        load_valid,
    input  logic [4:0]  load_rd,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        wb_write_enable,
    output logic [4:0]  wb_addr_rd,
    output logic [31:0] wb_data_rd,
    input  logic [4:0]  query_rs1,
    input  logic [4:0]  query_rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [31:0] busy_mask,
    output logic        waw_error
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [4:0]       fifo_rd   [FIFO_DEPTH];
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      busy;
    logic [31:0]      busy_next;
    logic             wb_is_load;
    logic             accept;
    logic             drain;

    // Ready looks only at the start-of-cycle count, so a full FIFO never accepts even if it drains.
    assign load_ready = (count < CNT_W'(FIFO_DEPTH));
    assign accept     = load_valid & load_ready;
    assign drain      = ~alu_valid & (count != '0);

    assign busy_mask = busy;
    assign rs1_busy  = busy[query_rs1];
    assign rs2_busy  = busy[query_rs2];

    always_comb begin
        count_next = count;
        case ({accept, drain})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // A load's busy bit drops at the edge that finishes its register-file write; a new issue wins.
    always_comb begin
        busy_next = busy;
        if (wb_is_load && wb_write_enable) begin
            busy_next[wb_addr_rd] = 1'b0;
        end
        if (load_issue_valid && (load_issue_rd != 5'd0)) begin
            busy_next[load_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            fifo_rd[tail_ptr]   <= load_rd;
            fifo_data[tail_ptr] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            busy     <= '0;
        end else begin
            if (accept) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (drain) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count_next;
            busy  <= busy_next;
        end
    end

    // ALU always owns the port when valid; x0 destinations still move data but never write.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_write_enable <= 1'b0;
            wb_addr_rd      <= 5'd0;
            wb_data_rd      <= 32'd0;
            wb_is_load      <= 1'b0;
        end else if (alu_valid) begin
            wb_write_enable <= (alu_rd != 5'd0);
            wb_addr_rd      <= alu_rd;
            wb_data_rd      <= alu_data;
            wb_is_load      <= 1'b0;
        end else if (drain) begin
            wb_write_enable <= (fifo_rd[head_ptr] != 5'd0);
            wb_addr_rd      <= fifo_rd[head_ptr];
            wb_data_rd      <= fifo_data[head_ptr];
            wb_is_load      <= 1'b1;
        end else begin
            wb_write_enable <= 1'b0;
            wb_is_load      <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            waw_error <= 1'b0;
        end else if (alu_valid && (alu_rd != 5'd0) && busy[alu_rd]) begin
            waw_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: hand-checked scenarios plus a queue-based
// reference model compared against the DUT on every cycle.
module tb_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_issue_valid;
    logic [4:0]  load_issue_rd;
    logic        load_valid;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        load_ready;
    logic        wb_write_enable;
    logic [4:0]  wb_addr_rd;
    logic [31:0] wb_data_rd;
    logic [4:0]  query_rs1;
    logic [4:0]  query_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [31:0] busy_mask;
    logic        waw_error;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .alu_valid(alu_valid),
        .alu_rd(alu_rd),
        .alu_data(alu_data),
        .load_issue_valid(load_issue_valid),
        .load_issue_rd(load_issue_rd),
        .load_valid(load_valid),
        .load_rd(load_rd),
        .load_data(load_data),
        .load_ready(load_ready),
        .wb_write_enable(wb_write_enable),
        .wb_addr_rd(wb_addr_rd),
        .wb_data_rd(wb_data_rd),
        .query_rs1(query_rs1),
        .query_rs2(query_rs2),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .busy_mask(busy_mask),
        .waw_error(waw_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: pending load returns as a queue of {rd, data}, busy registers as a bit set.
    logic [36:0] model_q [$];
    logic [36:0] m_entry;
    logic [31:0] m_busy;
    logic [31:0] m_busy_after;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_waw;
    logic        m_presenting_load;
    logic        m_ready_now;
    logic        model_live = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            model_q.delete();
            m_busy            = '0;
            m_we              = 1'b0;
            m_rd              = 5'd0;
            m_data            = 32'd0;
            m_waw             = 1'b0;
            m_presenting_load = 1'b0;
            model_live        = 1'b1;
        end else begin
            m_ready_now  = (model_q.size() < DEPTH);
            m_busy_after = m_busy;
            if (m_presenting_load && m_we) m_busy_after[m_rd] = 1'b0;
            if (load_issue_valid && load_issue_rd != 5'd0) m_busy_after[load_issue_rd] = 1'b1;
            if (alu_valid && alu_rd != 5'd0 && m_busy[alu_rd]) m_waw = 1'b1;
            if (alu_valid) begin
                m_we = (alu_rd != 5'd0);
                m_rd = alu_rd;
                m_data = alu_data;
                m_presenting_load = 1'b0;
            end else if (model_q.size() != 0) begin
                m_entry = model_q.pop_front();
                m_rd = m_entry[36:32];
                m_data = m_entry[31:0];
                m_we = (m_rd != 5'd0);
                m_presenting_load = 1'b1;
            end else begin
                m_we = 1'b0;
                m_presenting_load = 1'b0;
            end
            if (load_valid && m_ready_now) model_q.push_back({load_rd, load_data});
            m_busy = m_busy_after;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the clock edge.
    initial begin
        forever begin
            @(negedge clock);
            if (model_live) begin
                checkOutput("m_load_ready", load_ready, (model_q.size() < DEPTH));
                checkOutput("m_wb_we", wb_write_enable, m_we);
                checkOutput("m_wb_addr", wb_addr_rd, m_rd);
                checkOutput("m_wb_data", wb_data_rd, m_data);
                checkOutput("m_busy_mask", busy_mask, m_busy);
                checkOutput("m_rs1_busy", rs1_busy, m_busy[query_rs1]);
                checkOutput("m_rs2_busy", rs2_busy, m_busy[query_rs2]);
                checkOutput("m_waw", waw_error, m_waw);
            end
        end
    end

    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic iv, input logic [4:0] ir,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_valid        = av;
        alu_rd           = ar;
        alu_data         = ad;
        load_issue_valid = iv;
        load_issue_rd    = ir;
        load_valid       = lv;
        load_rd          = lr;
        load_data        = ld;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        query_rs1 = 5'd0;
        query_rs2 = 5'd0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("rst_busy", busy_mask, 32'h0);
        checkOutput("rst_we", wb_write_enable, 1'b0);
        checkOutput("rst_ready", load_ready, 1'b1);
        checkOutput("rst_waw", waw_error, 1'b0);

        // ALU alone
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        tick(); idle(); #1;
        checkOutput("alu_we", wb_write_enable, 1'b1);
        checkOutput("alu_addr", wb_addr_rd, 5'd5);
        checkOutput("alu_data", wb_data_rd, 32'h12345678);
        tick(); #1;
        checkOutput("alu_we_off", wb_write_enable, 1'b0);
        checkOutput("alu_addr_hold", wb_addr_rd, 5'd5);

        // Load path with scoreboard
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0);
        tick(); idle(); query_rs1 = 5'd7; #1;
        checkOutput("ld_busy7_c2", busy_mask, 32'h0000_0080);
        checkOutput("ld_rs1_c2", rs1_busy, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF); #1;
        checkOutput("ld_ready_c3", load_ready, 1'b1);
        checkOutput("ld_rs1_c3", rs1_busy, 1'b1);
        tick(); idle(); #1;
        checkOutput("ld_we_c4", wb_write_enable, 1'b0);
        checkOutput("ld_rs1_c4", rs1_busy, 1'b1);
        tick(); #1;
        checkOutput("ld_we_c5", wb_write_enable, 1'b1);
        checkOutput("ld_addr_c5", wb_addr_rd, 5'd7);
        checkOutput("ld_data_c5", wb_data_rd, 32'hDEADBEEF);
        checkOutput("ld_rs1_c5", rs1_busy, 1'b1);
        tick(); #1;
        checkOutput("ld_busy_c6", busy_mask, 32'h0);
        checkOutput("ld_rs1_c6", rs1_busy, 1'b0);
        query_rs1 = 5'd0;

        // Collision: ALU held three cycles while loads pile up behind it
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 5'd8, 32'h88); #1;
        checkOutput("col_ready_c1", load_ready, 1'b1);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 1'b1, 5'd9, 32'h99); #1;
        checkOutput("col_ready_c2", load_ready, 1'b1);
        checkOutput("col_data_c2", wb_data_rd, 32'h33);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 1'b1, 5'd10, 32'hAA); #1;
        checkOutput("col_ready_c3", load_ready, 1'b0);
        checkOutput("col_data_c3", wb_data_rd, 32'h34);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd10, 32'hAA); #1;
        checkOutput("col_ready_c4", load_ready, 1'b0);
        checkOutput("col_data_c4", wb_data_rd, 32'h35);
        checkOutput("col_addr_c4", wb_addr_rd, 5'd3);
        tick(); #1;
        checkOutput("col_addr_c5", wb_addr_rd, 5'd8);
        checkOutput("col_data_c5", wb_data_rd, 32'h88);
        checkOutput("col_ready_c5", load_ready, 1'b1);
        tick(); idle(); #1;
        checkOutput("col_addr_c6", wb_addr_rd, 5'd9);
        tick(); #1;
        checkOutput("col_addr_c7", wb_addr_rd, 5'd10);
        checkOutput("col_data_c7", wb_data_rd, 32'hAA);
        tick(); #1;
        checkOutput("col_we_c8", wb_write_enable, 1'b0);

        // x0 destinations from every source
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 1'b1, 5'd0, 32'h66);
        tick(); idle(); #1;
        checkOutput("x0_alu_we", wb_write_enable, 1'b0);
        checkOutput("x0_busy", busy_mask, 32'h0);
        tick(); #1;
        checkOutput("x0_ld_we", wb_write_enable, 1'b0);
        checkOutput("x0_ld_data", wb_data_rd, 32'h66);
        tick(); #1;
        checkOutput("x0_drained_ready", load_ready, 1'b1);

        // Sticky WAW error, then retire the outstanding load
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0); #1;
        checkOutput("waw_before", waw_error, 1'b0);
        tick(); idle(); #1;
        checkOutput("waw_set", waw_error, 1'b1);
        checkOutput("waw_alu_we", wb_write_enable, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4444);
        tick(); idle();
        tick(); tick(); #1;
        checkOutput("waw_sticky", waw_error, 1'b1);
        checkOutput("waw_busy_clear", busy_mask, 32'h0);

        // Reset mid-stream with two buffered loads
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 1'b1, 5'd8, 32'h800);
        tick();
        applyStimulus(1'b1, 5'd2, 32'h23, 1'b0, 5'd0, 1'b1, 5'd9, 32'h900);
        tick();
        applyStimulus(1'b1, 5'd3, 32'h24, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
        reset = 1'b1; #1;
        checkOutput("mid_busy", busy_mask, 32'h0000_0300);
        checkOutput("mid_ready", load_ready, 1'b0);
        tick(); reset = 1'b0; idle(); #1;
        checkOutput("post_rst_busy", busy_mask, 32'h0);
        checkOutput("post_rst_ready", load_ready, 1'b1);
        checkOutput("post_rst_we", wb_write_enable, 1'b0);
        checkOutput("post_rst_waw", waw_error, 1'b0);
        checkOutput("post_rst_data", wb_data_rd, 32'h0);
        tick(); #1;
        checkOutput("post_rst_discard", wb_write_enable, 1'b0);

        // Same-edge set and clear of rd=6
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 5'd6, 32'h666);
        tick(); idle();
        tick();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0); #1;
        checkOutput("same_we", wb_write_enable, 1'b1);
        checkOutput("same_addr", wb_addr_rd, 5'd6);
        tick(); idle(); query_rs2 = 5'd6; #1;
        checkOutput("same_busy", busy_mask, 32'h0000_0040);
        checkOutput("same_rs2", rs2_busy, 1'b1);
        tick(); tick(); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
